// File: rtl/decoder_pkg.sv
// Shared decode constants: RV32I/M opcodes, ALU op indices (same ordering as the ALU),
// decoder FSM encoding and the combinational decode result bundle.
package decoder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned REG_W = 5;

  typedef logic [IDX_W-1:0] alu_idx_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam alu_idx_t ALU_ADD    = 6'd0;
  localparam alu_idx_t ALU_SUB    = 6'd1;
  localparam alu_idx_t ALU_SLL    = 6'd2;
  localparam alu_idx_t ALU_SLT    = 6'd3;
  localparam alu_idx_t ALU_SLTU   = 6'd4;
  localparam alu_idx_t ALU_XOR    = 6'd5;
  localparam alu_idx_t ALU_SRL    = 6'd6;
  localparam alu_idx_t ALU_SRA    = 6'd7;
  localparam alu_idx_t ALU_OR     = 6'd8;
  localparam alu_idx_t ALU_AND    = 6'd9;
  localparam alu_idx_t ALU_MUL    = 6'd10;
  localparam alu_idx_t ALU_MULH   = 6'd11;
  localparam alu_idx_t ALU_MULHSU = 6'd12;
  localparam alu_idx_t ALU_MULHU  = 6'd13;
  localparam alu_idx_t ALU_DIV    = 6'd14;
  localparam alu_idx_t ALU_DIVU   = 6'd15;
  localparam alu_idx_t ALU_REM    = 6'd16;
  localparam alu_idx_t ALU_REMU   = 6'd17;
  localparam alu_idx_t ALU_ADDI   = 6'd18;
  localparam alu_idx_t ALU_SLTI   = 6'd19;
  localparam alu_idx_t ALU_SLTIU  = 6'd20;
  localparam alu_idx_t ALU_XORI   = 6'd21;
  localparam alu_idx_t ALU_ORI    = 6'd22;
  localparam alu_idx_t ALU_ANDI   = 6'd23;
  localparam alu_idx_t ALU_SLLI   = 6'd24;
  localparam alu_idx_t ALU_SRLI   = 6'd25;
  localparam alu_idx_t ALU_SRAI   = 6'd26;
  localparam alu_idx_t ALU_LB     = 6'd27;
  localparam alu_idx_t ALU_LH     = 6'd28;
  localparam alu_idx_t ALU_LW     = 6'd29;
  localparam alu_idx_t ALU_LBU    = 6'd30;
  localparam alu_idx_t ALU_LHU    = 6'd31;
  localparam alu_idx_t ALU_SB     = 6'd32;
  localparam alu_idx_t ALU_SH     = 6'd33;
  localparam alu_idx_t ALU_SW     = 6'd34;
  localparam alu_idx_t ALU_BEQ    = 6'd35;
  localparam alu_idx_t ALU_BNE    = 6'd36;
  localparam alu_idx_t ALU_BLT    = 6'd37;
  localparam alu_idx_t ALU_BGE    = 6'd38;
  localparam alu_idx_t ALU_BLTU   = 6'd39;
  localparam alu_idx_t ALU_BGEU   = 6'd40;
  localparam alu_idx_t ALU_JAL    = 6'd41;
  localparam alu_idx_t ALU_JALR   = 6'd42;
  localparam alu_idx_t ALU_LUI    = 6'd43;
  localparam alu_idx_t ALU_AUIPC  = 6'd44;
  localparam alu_idx_t OP_NOP     = 6'd63;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2
  } dec_state_t;

  typedef struct packed {
    alu_idx_t idx;
    logic     illegal;
    logic     is_ctrl;
    logic     is_mem;
  } decode_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32I(+M) word -> ALU op index decode.
// DECODER_RV32M_EN: when defined, funct7=0000001 on OP_REG decodes to the M-extension ops.
module instr_decode_comb
  import decoder_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output decode_t         dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_idx_t   idx;
  logic       bad;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    idx = OP_NOP;
    bad = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: idx = ALU_ADD;
            3'b001: idx = ALU_SLL;
            3'b010: idx = ALU_SLT;
            3'b011: idx = ALU_SLTU;
            3'b100: idx = ALU_XOR;
            3'b101: idx = ALU_SRL;
            3'b110: idx = ALU_OR;
            3'b111: idx = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  idx = ALU_SUB;
            3'b101:  idx = ALU_SRA;
            default: bad = 1'b1;
          endcase
`ifdef DECODER_RV32M_EN
        end else if (funct7 == 7'b0000001) begin
          // MUL..REMU occupy consecutive indices in funct3 order
          idx = ALU_MUL + alu_idx_t'(funct3);
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        case (funct3)
          3'b000: idx = ALU_ADDI;
          3'b010: idx = ALU_SLTI;
          3'b011: idx = ALU_SLTIU;
          3'b100: idx = ALU_XORI;
          3'b110: idx = ALU_ORI;
          3'b111: idx = ALU_ANDI;
          3'b001: begin
            if (funct7 == 7'b0000000) idx = ALU_SLLI;
            else                      bad = 1'b1;
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      idx = ALU_SRLI;
            else if (funct7 == 7'b0100000) idx = ALU_SRAI;
            else                           bad = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        case (funct3)
          3'b000:  idx = ALU_LB;
          3'b001:  idx = ALU_LH;
          3'b010:  idx = ALU_LW;
          3'b100:  idx = ALU_LBU;
          3'b101:  idx = ALU_LHU;
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000:  idx = ALU_SB;
          3'b001:  idx = ALU_SH;
          3'b010:  idx = ALU_SW;
          default: bad = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  idx = ALU_BEQ;
          3'b001:  idx = ALU_BNE;
          3'b100:  idx = ALU_BLT;
          3'b101:  idx = ALU_BGE;
          3'b110:  idx = ALU_BLTU;
          3'b111:  idx = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OP_JAL:   idx = ALU_JAL;
      OP_JALR: begin
        if (funct3 == 3'b000) idx = ALU_JALR;
        else                  bad = 1'b1;
      end
      OP_LUI:   idx = ALU_LUI;
      OP_AUIPC: idx = ALU_AUIPC;
      default:  bad = 1'b1;
    endcase
    if (bad) idx = OP_NOP;
  end

  assign dec.idx     = idx;
  assign dec.illegal = bad;
  assign dec.is_ctrl = !bad && (idx >= ALU_BEQ) && (idx <= ALU_JALR);
  assign dec.is_mem  = !bad && (idx >= ALU_LB) && (idx <= ALU_SW);

endmodule

// File: rtl/instr_decoder.sv
// Decode stage: fetch handshake, registered issue to the ALU, 2-cycle control-flow hold-off.
// DECODER_RV32M_EN (see instr_decode_comb) enables M-extension decode.
module instr_decoder
  import decoder_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fetch_valid,
  input  logic [XLEN-1:0]  i_fetch_instr,
  input  logic [XLEN-1:0]  i_fetch_pc,
  output logic             o_fetch_ready,
  input  logic             i_stall,
  input  logic             i_jump_DV,
  output logic [XLEN-1:0]  o_instruction,
  output logic [XLEN-1:0]  o_IR,
  output logic [XLEN-1:0]  o_PC,
  output logic [REG_W-1:0] o_rs1,
  output logic [REG_W-1:0] o_rs2,
  output logic [REG_W-1:0] o_rd,
  output logic             o_valid,
  output logic             o_mem_op,
  output logic             o_illegal
);

  localparam int unsigned FLUSH_W = 16;

  dec_state_t         state;
  dec_state_t         state_nxt;
  decode_t            dec;
  logic               accept;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               unused_flush;

  instr_decode_comb u_decode (
    .instr (i_fetch_instr),
    .dec   (dec)
  );

  assign accept = i_fetch_valid && o_fetch_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state: control-flow ops hold fetch off while the ALU resolves them
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (accept && dec.is_ctrl) state_nxt = ST_WAIT1;
      ST_WAIT1: state_nxt = ST_WAIT2;
      ST_WAIT2: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_fetch_ready = 1'b0;
    if (state == ST_RUN) o_fetch_ready = !i_stall;
  end

  // Issue registers: NOP every cycle unless a word is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_instruction <= XLEN'(OP_NOP);
      o_valid       <= 1'b0;
      o_mem_op      <= 1'b0;
      o_illegal     <= 1'b0;
      o_IR          <= '0;
      o_PC          <= '0;
      o_rs1         <= '0;
      o_rs2         <= '0;
      o_rd          <= '0;
    end else begin
      o_instruction <= XLEN'(OP_NOP);
      o_valid       <= 1'b0;
      o_mem_op      <= 1'b0;
      o_illegal     <= 1'b0;
      if (accept) begin
        o_instruction <= XLEN'(dec.idx);
        o_valid       <= !dec.illegal;
        o_mem_op      <= dec.is_mem;
        o_illegal     <= dec.illegal;
        o_IR          <= i_fetch_instr;
        o_PC          <= i_fetch_pc;
        o_rs1         <= i_fetch_instr[19:15];
        o_rs2         <= i_fetch_instr[24:20];
        o_rd          <= i_fetch_instr[11:7];
      end
    end
  end

  // Taken control-flow count, sampled in the cycle the ALU reports it
  always_ff @(posedge i_clk) begin
    if (i_rst)                               flush_cnt <= '0;
    else if (state == ST_WAIT2 && i_jump_DV) flush_cnt <= flush_cnt + FLUSH_W'(1);
  end

  assign unused_flush = ^flush_cnt;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: issued transactions go through a scoreboard queue.
module tb_instr_decoder;

  typedef struct packed {
    logic [31:0] ins;
    logic        v;
    logic        ill;
    logic        mem;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] ir;
    logic [31:0] pc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_instr = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready;
  logic        stall = 1'b0;
  logic        jump_dv = 1'b0;
  logic [31:0] instruction;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        valid;
  logic        mem_op;
  logic        illegal;

  int   n_cmp = 0;
  int   n_fail = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  instr_decoder dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_valid (fetch_valid),
    .i_fetch_instr (fetch_instr),
    .i_fetch_pc    (fetch_pc),
    .o_fetch_ready (fetch_ready),
    .i_stall       (stall),
    .i_jump_DV     (jump_dv),
    .o_instruction (instruction),
    .o_IR          (ir),
    .o_PC          (pc),
    .o_rs1         (rs1),
    .o_rs2         (rs2),
    .o_rd          (rd),
    .o_valid       (valid),
    .o_mem_op      (mem_op),
    .o_illegal     (illegal)
  );

  function automatic obs_t sample();
    return {instruction, valid, illegal, mem_op, rd, rs1, rs2, ir, pc};
  endfunction

  function automatic obs_t mk(input int idx, input logic v, input logic ill, input logic mem,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] w, input logic [31:0] p);
    obs_t o;
    o.ins = 32'(idx);
    o.v = v;
    o.ill = ill;
    o.mem = mem;
    o.rd = d;
    o.rs1 = s1;
    o.rs2 = s2;
    o.ir = w;
    o.pc = p;
    return o;
  endfunction

  // Present a word and hold it until accepted; returns #1 after the accepting edge
  task automatic send(input logic [31:0] w, input logic [31:0] p);
    bit ok = 1'b0;
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_instr = w;
    fetch_pc = p;
    for (int k = 0; k < 16 && !ok; k++) begin
      if (fetch_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout word=%h got ready=%b required ready=1", w, fetch_ready);
      fetch_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    e = mk(63, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL reset_values got=%h required=%h", got, e); end
    n_cmp++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b required=1", fetch_ready); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    obs_t got;
    obs_t e;
    sb.push_back(mk(18, 1, 0, 0, 1, 0, 5, 32'h00500093, 32'h100));
    send(32'h00500093, 32'h100);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL addi_issue got=%h required=%h", got, e); end
    @(posedge clk);
    #1;
    got = sample();
    e = mk(63, 0, 0, 0, 1, 0, 5, 32'h00500093, 32'h100);
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL addi_then_nop got=%h required=%h", got, e); end
  endtask

  task automatic test_back_to_back();
    obs_t got;
    obs_t e;
    sb.push_back(mk(0, 1, 0, 0, 3, 1, 2, 32'h002081B3, 32'h104));
    send(32'h002081B3, 32'h104);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_add got=%h required=%h", got, e); end
    n_cmp++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b required=1", fetch_ready); end
    sb.push_back(mk(1, 1, 0, 0, 3, 1, 2, 32'h402081B3, 32'h108));
    send(32'h402081B3, 32'h108);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_sub got=%h required=%h", got, e); end
    n_cmp++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b required=1", fetch_ready); end
  endtask

  task automatic test_branch(input logic jdv, input logic [31:0] p);
    obs_t got;
    obs_t e;
    int   lows;
    sb.push_back(mk(35, 1, 0, 0, 8, 1, 2, 32'h00208463, p));
    send(32'h00208463, p);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL branch_issue jdv=%0b got=%h required=%h", jdv, got, e); end
    fetch_valid = 1'b1;
    fetch_instr = 32'h002081B3;
    fetch_pc = p + 32'd4;
    sb.push_back(mk(0, 1, 0, 0, 3, 1, 2, 32'h002081B3, p + 32'd4));
    lows = 0;
    while (fetch_ready !== 1'b1 && lows < 8) begin
      lows++;
      if (lows == 2) jump_dv = jdv;
      @(posedge clk);
      #1;
      jump_dv = 1'b0;
      if (lows == 1) begin
        got = sample();
        e = mk(63, 0, 0, 0, 8, 1, 2, 32'h00208463, p);
        n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL branch_wait_nop jdv=%0b got=%h required=%h", jdv, got, e); end
      end
    end
    n_cmp++;
    if (lows != 2) begin n_fail++; $display("FAIL branch_ready_low jdv=%0b got=%0d cycles required=2", jdv, lows); end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL branch_follow_add jdv=%0b got=%h required=%h", jdv, got, e); end
  endtask

  task automatic test_mul();
    obs_t got;
    obs_t e;
`ifdef DECODER_RV32M_EN
    sb.push_back(mk(10, 1, 0, 0, 3, 1, 2, 32'h022081B3, 32'h300));
`else
    sb.push_back(mk(63, 0, 1, 0, 3, 1, 2, 32'h022081B3, 32'h300));
`endif
    send(32'h022081B3, 32'h300);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL mul_decode got=%h required=%h", got, e); end
  endtask

  task automatic test_illegal();
    obs_t got;
    obs_t e;
    sb.push_back(mk(63, 0, 1, 0, 31, 31, 31, 32'hFFFFFFFF, 32'h304));
    send(32'hFFFFFFFF, 32'h304);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL illegal_pulse got=%h required=%h", got, e); end
    sb.push_back(mk(43, 1, 0, 0, 5, 8, 3, 32'h123452B7, 32'h308));
    send(32'h123452B7, 32'h308);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL lui_after_illegal got=%h required=%h", got, e); end
  endtask

  task automatic test_stall();
    obs_t got;
    obs_t e;
    stall = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = 32'h0000A183;
    fetch_pc = 32'h30C;
    sb.push_back(mk(29, 1, 0, 1, 3, 1, 0, 32'h0000A183, 32'h30C));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = sample();
      e = mk(63, 0, 0, 0, 5, 8, 3, 32'h123452B7, 32'h308);
      n_cmp++;
      if (got !== e) begin n_fail++; $display("FAIL stall_nop[%0d] got=%h required=%h", i, got, e); end
      n_cmp++;
      if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b required=0", i, fetch_ready); end
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL stall_release_lw got=%h required=%h", got, e); end
  endtask

  task automatic test_reset_mid_wait();
    obs_t got;
    obs_t e;
    sb.push_back(mk(35, 1, 0, 0, 8, 1, 2, 32'h00208463, 32'h400));
    send(32'h00208463, 32'h400);
    got = sample();
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL rstmid_branch got=%h required=%h", got, e); end
    rst = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = 32'h002081B3;
    fetch_pc = 32'h404;
    @(posedge clk);
    #1;
    got = sample();
    e = mk(63, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL rstmid_values got=%h required=%h", got, e); end
    n_cmp++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b required=1", fetch_ready); end
    rst = 1'b0;
    fetch_valid = 1'b0;
    @(posedge clk);
    #1;
    got = sample();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL rstmid_no_issue got=%h required=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch(1'b0, 32'h200);
    test_branch(1'b1, 32'h220);
    test_mul();
    test_illegal();
    test_stall();
    test_reset_mid_wait();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d left required=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
